rsa16_modinv: RTL

RSA16_MODINV -- requirements
Module: rsa16_modinv

---
 rtl/rsa16_modinv.sv | 119 +++++++++++
 1 files changed

// File: rtl/rsa16_modinv.sv
// Modular inverse d = e^-1 mod phi via the iterative extended Euclidean algorithm,
// one quotient step per clock, with a start-edge detector and a five-state control FSM.
module rsa16_modinv #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_e,
    input  logic [W-1:0] i_phi,
    output logic [W-1:0] o_d,
    output logic         o_err,
    output logic         o_end
);

    localparam int TW = W + 2;

    typedef enum logic [2:0] {IDLE, START, CALC, FIX, DONE} state_t;

    state_t state, state_next;

    logic                 start_q;
    logic                 start_pulse;
    logic [W-1:0]         r0, r1, phi_q;
    logic signed [TW-1:0] t0, t1;
    logic [W-1:0]         divisor, q, q_r1;
    logic signed [TW-1:0] q_s, q_t1;
    logic                 load, step, fix;

    // Map a Bezout coefficient in (-m, m) onto the canonical residue 0..m-1.
    function automatic logic [W-1:0] reduce_mod(input logic signed [TW-1:0] t,
                                                input logic [W-1:0] m);
        logic signed [TW-1:0] s;
        s = (t < 0) ? t + $signed({2'b00, m}) : t;
        return s[W-1:0];
    endfunction

    assign start_pulse = i_start & ~start_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_pulse) state_next = START;
            START:   state_next = CALC;
            CALC:    if (r1 == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load  = 1'b0;
        step  = 1'b0;
        fix   = 1'b0;
        o_end = 1'b0;
        case (state)
            IDLE:    o_end = 1'b1;
            START:   load = 1'b1;
            CALC:    step = (r1 != '0);
            FIX:     fix = 1'b1;
            DONE:    o_end = 1'b1;
            default: o_end = 1'b1;
        endcase
    end

    // The divisor is forced non-zero so the divider never sees 0, even when its result is unused.
    assign divisor = (r1 == '0) ? W'(1) : r1;
    assign q       = r0 / divisor;
    assign q_r1    = q * r1;
    assign q_s     = $signed({2'b00, q});
    assign q_t1    = q_s * t1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            start_q <= 1'b0;
            r0      <= '0;
            r1      <= '0;
            t0      <= '0;
            t1      <= '0;
            phi_q   <= '0;
            o_d     <= '0;
            o_err   <= 1'b0;
        end else begin
            start_q <= i_start;
            if (load) begin
                r0    <= i_phi;
                r1    <= i_e;
                t0    <= '0;
                t1    <= TW'(1);
                phi_q <= i_phi;
            end else if (step) begin
                r0 <= r1;
                r1 <= r0 - q_r1;
                t0 <= t1;
                t1 <= t0 - q_t1;
            end
            // A gcd of 1 means an inverse exists; phi of 0 or 1 never has a meaningful one.
            if (fix) begin
                if (r0 == W'(1) && phi_q > W'(1)) begin
                    o_d   <= reduce_mod(t0, phi_q);
                    o_err <= 1'b0;
                end else begin
                    o_d   <= '0;
                    o_err <= 1'b1;
                end
            end
        end
    end

endmodule
